// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg
// Shared types and helpers for the FIR output decimator and its skid buffer.
//   clog2_min1   : ceil(log2(n)) but never below 1, for counter widths
//   axis_beat_t  : one AXI-Stream beat (signed sample + tlast) at the FIR width
//   DECIM_MAX    : largest supported decimation factor
package fir_decim_pkg;

   localparam int DECIM_MAX      = 256;
   localparam int FIR_DATA_WIDTH = 16;

   typedef struct packed {
      logic signed [FIR_DATA_WIDTH-1:0] data;
      logic                             last;
   } axis_beat_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
// Two-entry registered AXI-Stream buffer: an output register plus one skid
// entry. Both in_ready and out_valid come straight from flops, so neither
// side sees a combinational path from the other.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   in_data/in_valid   : upstream beat (WIDTH bits, opaque payload)
//   in_ready           : upstream ready, low only while the skid entry is full
//   out_data/out_valid : registered downstream beat
//   out_ready          : downstream ready
module axis_skid_buffer #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] skid_data;
   logic             skid_full;
   logic             load_out;
   logic             in_fire;

   assign load_out = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign in_ready = !skid_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         skid_data <= '0;
         skid_full <= 1'b0;
      end else begin
         if (load_out) begin
            // A full skid entry always drains first; in_ready was low, so no
            // new beat can arrive in the same cycle.
            if (skid_full) begin
               out_data  <= skid_data;
               out_valid <= 1'b1;
               skid_full <= 1'b0;
            end else begin
               out_valid <= in_fire;
               if (in_fire) begin
                  out_data <= in_data;
               end
            end
         end else if (in_fire) begin
            skid_data <= in_data;
            skid_full <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_output_decimator.sv
// fir_output_decimator
// Decimates the FIR output stream by DECIM, always preserving frame ends.
// Default build: keeps the beat at phase 0 and any tlast beat (pick-first).
// With FIR_DECIM_AVG_EN defined: boxcar average over each phase window,
// emitted at phase DECIM-1 or tlast, scaled by >>> $clog2(DECIM).
// Ports:
//   clk, reset                          : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast    : input stream from the FIR
//   m_axis_tdata/tvalid/tready/tlast    : decimated output stream
module fir_output_decimator
   import fir_decim_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DECIM      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int            PW         = clog2_min1(DECIM);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

   if (DECIM < 1 || DECIM > DECIM_MAX) begin : g_bad_decim
      $error("fir_output_decimator: DECIM out of range 1..256");
   end

   logic [PW-1:0]         phase;
   logic                  in_fire;
   logic                  phase_end;
   logic                  fwd_valid;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic [DATA_WIDTH:0]   out_beat;

   assign in_fire   = s_axis_tvalid && s_axis_tready;
   assign phase_end = (phase == PHASE_LAST);

   // A tlast beat restarts the window so the next frame begins at phase 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (in_fire) begin
         if (s_axis_tlast || phase_end) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

`ifdef FIR_DECIM_AVG_EN
   localparam int SH = $clog2(DECIM);
   localparam int AW = DATA_WIDTH + PW;

   if ((DECIM & (DECIM - 1)) != 0) begin : g_bad_pow2
      $error("fir_output_decimator: averaging needs DECIM to be a power of two");
   end

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_sum;

   assign acc_sum   = acc + {{PW{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
   assign fwd_valid = in_fire && (phase_end || s_axis_tlast);
   // Arithmetic shift floors toward -inf; partial windows use the same scale.
   assign fwd_data  = DATA_WIDTH'(acc_sum >>> SH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (in_fire) begin
         acc <= fwd_valid ? '0 : acc_sum;
      end
   end
`else
   assign fwd_valid = in_fire && ((phase == '0) || s_axis_tlast);
   assign fwd_data  = s_axis_tdata;
`endif

   // Dropped beats never reach the buffer, so they cost no storage.
   axis_skid_buffer #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({s_axis_tlast, fwd_data}),
      .in_valid  (fwd_valid),
      .in_ready  (s_axis_tready),
      .out_data  (out_beat),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign m_axis_tlast = out_beat[DATA_WIDTH];
   assign m_axis_tdata = out_beat[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fir_output_decimator.sv
module tb_fir_output_decimator;

   localparam int DW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] d2_s_data, d2_m_data;
   logic          d2_s_valid, d2_s_ready, d2_s_last, d2_m_valid, d2_m_ready, d2_m_last;
   logic [DW-1:0] d4_s_data, d4_m_data;
   logic          d4_s_valid, d4_s_ready, d4_s_last, d4_m_valid, d4_m_ready, d4_m_last;
   logic [DW-1:0] d1_s_data, d1_m_data;
   logic          d1_s_valid, d1_s_ready, d1_s_last, d1_m_valid, d1_m_ready, d1_m_last;

   fir_output_decimator #(.DATA_WIDTH(DW), .DECIM(2)) u_d2 (
      .clk(clk), .reset(reset),
      .s_axis_tdata(d2_s_data), .s_axis_tvalid(d2_s_valid), .s_axis_tready(d2_s_ready),
      .s_axis_tlast(d2_s_last),
      .m_axis_tdata(d2_m_data), .m_axis_tvalid(d2_m_valid), .m_axis_tready(d2_m_ready),
      .m_axis_tlast(d2_m_last));

   fir_output_decimator #(.DATA_WIDTH(DW), .DECIM(4)) u_d4 (
      .clk(clk), .reset(reset),
      .s_axis_tdata(d4_s_data), .s_axis_tvalid(d4_s_valid), .s_axis_tready(d4_s_ready),
      .s_axis_tlast(d4_s_last),
      .m_axis_tdata(d4_m_data), .m_axis_tvalid(d4_m_valid), .m_axis_tready(d4_m_ready),
      .m_axis_tlast(d4_m_last));

   fir_output_decimator #(.DATA_WIDTH(DW), .DECIM(1)) u_d1 (
      .clk(clk), .reset(reset),
      .s_axis_tdata(d1_s_data), .s_axis_tvalid(d1_s_valid), .s_axis_tready(d1_s_ready),
      .s_axis_tlast(d1_s_last),
      .m_axis_tdata(d1_m_data), .m_axis_tvalid(d1_m_valid), .m_axis_tready(d1_m_ready),
      .m_axis_tlast(d1_m_last));

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({d2_s_ready, d2_m_valid, d2_m_last, d2_m_data} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset_d2: got rdy=%b v=%b l=%b d=%h want rdy=1 v=0 l=0 d=0000",
                  d2_s_ready, d2_m_valid, d2_m_last, d2_m_data);
      end
      checks++;
      if ({d4_s_ready, d4_m_valid, d4_m_last, d4_m_data} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset_d4: got rdy=%b v=%b l=%b d=%h want rdy=1 v=0 l=0 d=0000",
                  d4_s_ready, d4_m_valid, d4_m_last, d4_m_data);
      end
      checks++;
      if ({d1_s_ready, d1_m_valid, d1_m_last, d1_m_data} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset_d1: got rdy=%b v=%b l=%b d=%h want rdy=1 v=0 l=0 d=0000",
                  d1_s_ready, d1_m_valid, d1_m_last, d1_m_data);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({d2_s_ready, d2_m_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", d2_s_ready, d2_m_valid);
      end
   endtask

   task automatic test_dec2_basic();
      int vals[6]  = '{1, 2, 3, 4, 5, 6};
      int expv[6]  = '{1, 0, 1, 0, 1, 1};
      int lasts[6] = '{0, 0, 0, 0, 0, 1};
      d2_m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d2_s_valid = 1'b1;
         d2_s_data  = 16'(vals[i]);
         d2_s_last  = 1'(lasts[i]);
         @(posedge clk);
         #1;
         checks++;
         if (d2_m_valid !== 1'(expv[i]) || d2_s_ready !== 1'b1 ||
             (expv[i] != 0 && {d2_m_last, d2_m_data} !== {1'(lasts[i]), 16'(vals[i])})) begin
            errors++;
            $display("FAIL dec2_basic beat %0d: got v=%b l=%b d=%0d rdy=%b want v=%0d l=%0d d=%0d rdy=1",
                     i, d2_m_valid, d2_m_last, d2_m_data, d2_s_ready, expv[i], lasts[i], vals[i]);
         end
      end
      d2_s_valid = 1'b0;
      d2_s_last  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (d2_m_valid !== 1'b0) begin
         errors++;
         $display("FAIL dec2_idle: got v=%b want v=0", d2_m_valid);
      end
   endtask

   task automatic test_dec4();
      int vals[9]  = '{10, 20, 30, 40, 50, 7, 8, 9, 11};
      int lasts[9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
      int expv[9]  = '{1, 0, 0, 0, 1, 1, 0, 1, 1};
      d4_m_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         d4_s_valid = 1'b1;
         d4_s_data  = 16'(vals[i]);
         d4_s_last  = 1'(lasts[i]);
         @(posedge clk);
         #1;
         checks++;
         if (d4_m_valid !== 1'(expv[i]) ||
             (expv[i] != 0 && {d4_m_last, d4_m_data} !== {1'(lasts[i]), 16'(vals[i])})) begin
            errors++;
            $display("FAIL dec4 beat %0d: got v=%b l=%b d=%0d want v=%0d l=%0d d=%0d",
                     i, d4_m_valid, d4_m_last, d4_m_data, expv[i], lasts[i], vals[i]);
         end
      end
      d4_s_valid = 1'b0;
      d4_s_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_dec1_random();
      logic [DW:0] q[$];
      int   sent = 0;
      int   recv = 0;
      int   cyc  = 0;
      logic stuck = 1'b0;
      logic in_acc, out_acc;
      while ((sent < 100 || q.size() > 0) && cyc < 2000) begin
         if (!stuck) begin
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
               d1_s_valid = 1'b1;
               d1_s_data  = 16'($urandom);
               d1_s_last  = ($urandom_range(0, 7) == 0);
            end else begin
               d1_s_valid = 1'b0;
            end
         end
         d1_m_ready = 1'($urandom_range(0, 1));
         if (d1_m_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL dec1_order: got v=1 d=%h with no beat outstanding", d1_m_data);
            end else if ({d1_m_last, d1_m_data} !== q[0]) begin
               errors++;
               $display("FAIL dec1_order: got l=%b d=%h want l=%b d=%h",
                        d1_m_last, d1_m_data, q[0][DW], q[0][DW-1:0]);
            end
         end
         out_acc = d1_m_valid && d1_m_ready;
         in_acc  = d1_s_valid && d1_s_ready;
         if (out_acc && q.size() > 0) begin
            void'(q.pop_front());
            recv++;
         end
         if (in_acc) begin
            q.push_back({d1_s_last, d1_s_data});
            sent++;
         end
         stuck = d1_s_valid && !in_acc;
         @(posedge clk);
         #1;
         cyc++;
      end
      d1_s_valid = 1'b0;
      d1_m_ready = 1'b1;
      checks++;
      if (recv != 100 || cyc >= 2000) begin
         errors++;
         $display("FAIL dec1_count: got recv=%0d cycles=%0d want recv=100 cycles<2000", recv, cyc);
      end
      @(posedge clk);
      #1;
      checks++;
      if (d1_m_valid !== 1'b0) begin
         errors++;
         $display("FAIL dec1_dup: got v=%b d=%h after drain want v=0", d1_m_valid, d1_m_data);
      end
   endtask

   task automatic test_stall();
      logic [DW:0] q[$];
      int   phase  = 0;
      int   nxt    = 1;
      int   acc_in = 0;
      int   recv   = 0;
      int   cyc    = 0;
      logic stuck  = 1'b0;
      logic in_acc, out_acc;
      while ((nxt <= 20 || q.size() > 0) && cyc < 500) begin
         d2_m_ready = (cyc >= 10);
         if (!stuck) begin
            if (nxt <= 20) begin
               d2_s_valid = 1'b1;
               d2_s_data  = 16'(nxt);
               d2_s_last  = (nxt == 20);
            end else begin
               d2_s_valid = 1'b0;
               d2_s_last  = 1'b0;
            end
         end
         if (cyc == 10) begin
            checks++;
            if (d2_s_ready !== 1'b0 || acc_in != 3) begin
               errors++;
               $display("FAIL stall_ready: got rdy=%b accepted=%0d want rdy=0 accepted=3",
                        d2_s_ready, acc_in);
            end
         end
         if (d2_m_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL stall_order: got v=1 d=%0d with no beat outstanding", d2_m_data);
            end else if ({d2_m_last, d2_m_data} !== q[0]) begin
               errors++;
               $display("FAIL stall_order: got l=%b d=%0d want l=%b d=%0d",
                        d2_m_last, d2_m_data, q[0][DW], q[0][DW-1:0]);
            end
         end
         out_acc = d2_m_valid && d2_m_ready;
         in_acc  = d2_s_valid && d2_s_ready;
         if (out_acc && q.size() > 0) begin
            void'(q.pop_front());
            recv++;
         end
         if (in_acc) begin
            if (phase == 0 || d2_s_last) q.push_back({d2_s_last, d2_s_data});
            phase = d2_s_last ? 0 : (phase + 1) % 2;
            nxt++;
            acc_in++;
         end
         stuck = d2_s_valid && !in_acc;
         @(posedge clk);
         #1;
         cyc++;
      end
      d2_s_valid = 1'b0;
      d2_s_last  = 1'b0;
      d2_m_ready = 1'b1;
      checks++;
      if (recv != 11 || cyc >= 500) begin
         errors++;
         $display("FAIL stall_count: got recv=%0d cycles=%0d want recv=11 cycles<500", recv, cyc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      d2_m_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         d2_s_valid = 1'b1;
         d2_s_data  = 16'(i);
         d2_s_last  = 1'b0;
         @(posedge clk);
         #1;
      end
      d2_s_valid = 1'b0;
      checks++;
      if ({d2_m_valid, d2_s_ready, d2_m_data} !== {1'b1, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL rstmid_pre: got v=%b rdy=%b d=%0d want v=1 rdy=0 d=1",
                  d2_m_valid, d2_s_ready, d2_m_data);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({d2_m_valid, d2_s_ready, d2_m_last, d2_m_data} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL rstmid_async: got v=%b rdy=%b l=%b d=%h want v=0 rdy=1 l=0 d=0000",
                  d2_m_valid, d2_s_ready, d2_m_last, d2_m_data);
      end
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      d2_m_ready = 1'b1;
      d2_s_valid = 1'b1;
      d2_s_data  = 16'd7;
      d2_s_last  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({d2_m_valid, d2_m_last, d2_m_data} !== {1'b1, 1'b0, 16'd7}) begin
         errors++;
         $display("FAIL rstmid_first: got v=%b l=%b d=%0d want v=1 l=0 d=7",
                  d2_m_valid, d2_m_last, d2_m_data);
      end
      d2_s_data = 16'd8;
      d2_s_last = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({d2_m_valid, d2_m_last, d2_m_data} !== {1'b1, 1'b1, 16'd8}) begin
         errors++;
         $display("FAIL rstmid_tail: got v=%b l=%b d=%0d want v=1 l=1 d=8",
                  d2_m_valid, d2_m_last, d2_m_data);
      end
      d2_s_valid = 1'b0;
      d2_s_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask

`ifdef FIR_DECIM_AVG_EN
   task automatic test_avg();
      int vals[6]  = '{4, 8, -4, -9, 3, 3};
      int lasts[6] = '{0, 0, 0, 0, 0, 1};
      int expv[6]  = '{0, 0, 0, 1, 0, 1};
      int expd[6]  = '{0, 0, 0, -1, 0, 1};
      d4_m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d4_s_valid = 1'b1;
         d4_s_data  = 16'(vals[i]);
         d4_s_last  = 1'(lasts[i]);
         @(posedge clk);
         #1;
         checks++;
         if (d4_m_valid !== 1'(expv[i]) ||
             (expv[i] != 0 && {d4_m_last, d4_m_data} !== {1'(lasts[i]), 16'(expd[i])})) begin
            errors++;
            $display("FAIL avg beat %0d: got v=%b l=%b d=%h want v=%0d l=%0d d=%h",
                     i, d4_m_valid, d4_m_last, d4_m_data, expv[i], lasts[i], 16'(expd[i]));
         end
      end
      d4_s_valid = 1'b0;
      d4_s_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      d2_s_data = '0; d2_s_valid = 1'b0; d2_s_last = 1'b0; d2_m_ready = 1'b1;
      d4_s_data = '0; d4_s_valid = 1'b0; d4_s_last = 1'b0; d4_m_ready = 1'b1;
      d1_s_data = '0; d1_s_valid = 1'b0; d1_s_last = 1'b0; d1_m_ready = 1'b1;
      test_reset();
`ifdef FIR_DECIM_AVG_EN
      test_avg();
      test_dec1_random();
`else
      test_dec2_basic();
      test_dec4();
      test_dec1_random();
      test_stall();
      test_reset_mid();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_output_decimator.md
Name: fir_output_decimator

Overview:
- AXI-Stream stage directly downstream of the single-stage pipelined FIR; consumes its m_axis_fir_* stream.
- Keeps one sample in every DECIM and forwards it to the next consumer.
- Frame boundaries (tlast) are always preserved.
- Output is fully registered through a 2-entry skid buffer, so both tready and tvalid are register outputs.

Parameters:
- DATA_WIDTH, 16, sample width; matches the FIR output width, two's complement.
- DECIM, 2, decimation factor; legal range 1..256; DECIM=1 is pass-through with 1-cycle latency.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  signed sample from the FIR.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready (registered).
- s_axis_tlast  in  1  last beat of frame.
- m_axis_tdata  out  DATA_WIDTH  signed decimated sample.
- m_axis_tvalid  out  1  output beat valid (registered).
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of decimated frame.

Behaviour:
- Clock and reset: one clock. reset is asynchronous, active-low.
- Reset values (asserting reset mid-operation discards all buffered beats and clears the phase):
  - s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Phase counter=0.
  - Skid entry empty.
- Accept: an input beat is accepted on s_axis_tvalid && s_axis_tready.
- Phase counter (width $clog2(DECIM), minimum 1):
  - Increments on each accepted beat and wraps DECIM-1 -> 0.
  - Forced to 0 after an accepted beat with tlast=1.
- Forward rule: an accepted beat is forwarded iff phase==0 OR tlast==1. All other accepted beats are discarded and consume no storage.
- Forward with tlast: a forwarded beat carries its own tlast. A tlast beat at phase!=0 is forwarded with its own data (the frame tail is never lost).
- Output register:
  - Loads when (!m_axis_tvalid || m_axis_tready).
  - Load source priority: skid entry if full, else the forwarded input beat.
  - The skid entry empties when its contents move to the output register.
- Skid entry: captures a forwarded beat when the output register is full and m_axis_tready=0.
- Ready: s_axis_tready = !skid_full (registered). Deasserts the cycle after the skid entry fills.
- Latency: 1 cycle from forwarded input acceptance to m_axis_tvalid when the output register is free.
- Throughput: one input beat per cycle sustained while m_axis_tready=1.
- AXI rules:
  - m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid && !m_axis_tready.
  - tvalid never depends combinationally on tready.
- Simultaneous output drain and input accept with the skid entry full: skid moves to output; the input beat is not accepted (tready was 0).
- Arithmetic: data passes unmodified in the default build.

Optional Feature:
- Macro: FIR_DECIM_AVG_EN.
- Defined: boxcar-average decimation.
  - Accumulator width DATA_WIDTH+$clog2(DECIM) sums every accepted beat in the phase window.
  - Output = accumulator arithmetic-shifted right by $clog2(DECIM), truncated toward -inf.
  - Emitted on the beat with phase==DECIM-1 or tlast.
  - Accumulator clears after each emitted beat.
  - A partial window at tlast uses the same shift.
  - DECIM must be a power of two; elaboration error otherwise.
- Undefined: pick-first decimation as in Behaviour; no accumulator logic is synthesized.

Decomposition:
- Package fir_decim_pkg:
  - function clog2_min1(n).
  - Typedef axis_beat_t as a packed struct {logic signed [DATA_WIDTH-1:0] data; logic last;} parameterised via a macro-free width constant.
  - Localparam DECIM_MAX=256.
- Sub-module axis_skid_buffer:
  - Holds the output register, skid entry, and ready logic.
  - Generic on width; reused elsewhere in the FIR chain.

Test Plan:
- DECIM=2, inputs 1,2,3,4,5,6 contiguous, tlast on 6, m_tready=1 -> outputs 1,3,5,6; tlast only on 6; each output 1 cycle after its input.
- DECIM=4, frame 10,20,30,40,50 (tlast on 50), then 7,8 -> outputs 10,50(last),7; the phase restart after tlast is proven by 7 appearing.
- DECIM=1, 100 random beats, m_tready random 50% -> output identical to input; no beat lost or duplicated; data stable while stalled.
- DECIM=2, m_tready held 0 for 10 cycles during a continuous stream -> s_tready drops within 2 cycles of the second forwarded beat; no data loss after release.
- Reset asserted mid-frame with output valid -> m_tvalid=0 and s_tready=1 immediately (async); next frame's first sample is forwarded.
- FIR_DECIM_AVG_EN, DECIM=4, inputs 4,8,-4,-9 -> output -1 (sum -1 >>2 = -1); inputs 3,3 with tlast -> output 1.
